// File: rtl/hdmi_line_prefetch.sv
// hdmi_line_prefetch
//
// Pixel source that sits directly in front of the HDMI output stage and runs on
// its pixel clock. Framebuffer lines (RGB565, two pixels per 32-bit word) are
// fetched over a simple req/ack memory port into a two-bank line buffer, one
// line ahead of the scan. The output stage asks for a pixel through nextX/nextY
// and gets the expanded 8-bit red/green/blue one cycle later.
//
// Ports
//   pixclk     pixel clock, the only clock
//   reset      synchronous, active-high
//   nextX      next pixel X from the output stage (saturates at WIDTH-1 in blanking)
//   nextY      next pixel Y from the output stage (saturates at HEIGHT-1 in blanking)
//   hSync      high during horizontal sync
//   vSync      high during vertical sync
//   fb_base    framebuffer byte address (4-aligned), latched on the vSync rise
//   mem_req    read request, held until mem_ack
//   mem_addr   byte address of the requested word, held until mem_ack
//   mem_ack    request accepted, mem_rdata valid in the same cycle
//   mem_rdata  [15:0] even pixel, [31:16] odd pixel, RGB565
//   red        expanded pixel red, registered
//   green      expanded pixel green, registered
//   blue       expanded pixel blue, registered
//   underrun   sticky error: a line was shown before it was fetched, or a
//              fetch request was dropped; cleared on reset or vSync rise

module hdmi_line_prefetch #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 480
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic [10:0] nextX,
  input  logic [10:0] nextY,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [31:0] fb_base,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        underrun
);

  localparam int HALF  = WIDTH / 2;
  localparam int IDX_W = $clog2(HALF);
  localparam int BUF_W = IDX_W + 1;

  localparam logic [IDX_W-1:0] LAST_WORD  = IDX_W'(HALF - 1);
  localparam logic [BUF_W-1:0] BANK1_OFS  = BUF_W'(HALF);
  localparam logic [31:0]      LINE_BYTES = 32'(WIDTH * 2);
  localparam logic [10:0]      HS_LIMIT   = 11'(HEIGHT - 2);
  localparam logic [10:0]      X_LIMIT    = 11'(WIDTH);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state;
  logic             hsync_q;
  logic             vsync_q;
  logic [1:0]       pending;
  logic [10:0]      fetch_line;
  logic [31:0]      line_base;
  logic [IDX_W-1:0] word_idx;
  logic             armed;

  logic [31:0] line_buf [0:2*HALF-1];

  logic             hs_rise;
  logic             vs_rise;
  logic             hs_req;
  logic             ack_take;
  logic             line_done;
  logic [BUF_W-1:0] wr_addr;
  logic [BUF_W-1:0] rd_addr;
  logic [31:0]      rd_word;
  logic [15:0]      pix;

  assign hs_rise   = hSync & ~hsync_q;
  assign vs_rise   = vSync & ~vsync_q;
  assign hs_req    = hs_rise && (nextY < HS_LIMIT);
  // An ack only counts while we are actually requesting; late acks are ignored.
  assign ack_take  = (state == FETCH) && mem_req && mem_ack;
  assign line_done = ack_take && (word_idx == LAST_WORD);

  // Bank is the line's LSB; bank 1 lives in the upper half of the buffer.
  assign wr_addr = {1'b0, word_idx} + (fetch_line[0] ? BANK1_OFS : '0);
  assign rd_addr = {1'b0, nextX[IDX_W:1]} + (nextY[0] ? BANK1_OFS : '0);
  assign rd_word = line_buf[rd_addr];
  assign pix     = nextX[0] ? rd_word[31:16] : rd_word[15:0];

  // Line buffer write port. Contents survive reset; a vSync rise in the same
  // cycle aborts the fetch, so that word is discarded.
  always_ff @(posedge pixclk) begin
    if (!reset && ack_take && !vs_rise) begin
      line_buf[wr_addr] <= mem_rdata;
    end
  end

  // Sync edge detection, fetch bookkeeping, fetch FSM, underrun tracking and
  // the registered pixel output.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state      <= IDLE;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      pending    <= 2'd0;
      fetch_line <= '0;
      line_base  <= '0;
      word_idx   <= '0;
      armed      <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      underrun   <= 1'b0;
    end else begin
      hsync_q <= hSync;
      vsync_q <= vSync;

      // RGB565 -> RGB888 by replicating the top bits into the low bits.
      red   <= {pix[15:11], pix[15:13]};
      green <= {pix[10:5],  pix[10:9]};
      blue  <= {pix[4:0],   pix[4:2]};

      if (vs_rise) begin
        // New frame: restart from line 0 and queue lines 0 and 1.
        line_base  <= fb_base;
        fetch_line <= '0;
        pending    <= 2'd2;
        state      <= IDLE;
        mem_req    <= 1'b0;
        word_idx   <= '0;
        underrun   <= 1'b0;
        armed      <= 1'b0;
      end else begin
        // The readiness check only starts once the scan has reached line 0;
        // during vertical blanking nextY sits at HEIGHT-1 of the old frame
        // while the new frame's counters have already restarted.
        if (nextY == 11'd0) begin
          armed <= 1'b1;
        end
        // Lines complete in order, so line L is ready once fetch_line > L.
        if (armed && (nextX < X_LIMIT) && (nextY >= fetch_line)) begin
          underrun <= 1'b1;
        end

        // A new request and a completion in the same cycle cancel out.
        case ({hs_req, line_done})
          2'b10: begin
            if (pending == 2'd2) begin
              underrun <= 1'b1;
            end else begin
              pending <= pending + 2'd1;
            end
          end
          2'b01:   pending <= pending - 2'd1;
          default: ;
        endcase

        case (state)
          IDLE: begin
            if (pending != 2'd0) begin
              state    <= FETCH;
              mem_req  <= 1'b1;
              mem_addr <= line_base;
              word_idx <= '0;
            end
          end
          FETCH: begin
            if (ack_take) begin
              mem_addr <= mem_addr + 32'd4;
              if (word_idx == LAST_WORD) begin
                // Drop the request for at least one cycle between lines.
                state      <= IDLE;
                mem_req    <= 1'b0;
                word_idx   <= '0;
                fetch_line <= fetch_line + 11'd1;
                line_base  <= line_base + LINE_BYTES;
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdmi_line_prefetch.sv
// tb_hdmi_line_prefetch
//
// Directed bench for hdmi_line_prefetch with the default 800x480 geometry.
// The memory model returns 0xF800_001F at byte address 0x1000 and
// {~addr[15:0], addr[15:0]} everywhere else, so expected pixels can be worked
// out by hand from the address alone.

module tb_hdmi_line_prefetch;

  logic        pixclk = 1'b0;
  logic        reset;
  logic [10:0] nextX;
  logic [10:0] nextY;
  logic        hSync;
  logic        vSync;
  logic [31:0] fb_base;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        underrun;

  int vectors = 0;
  int miscompares = 0;

  hdmi_line_prefetch #(.WIDTH(800), .HEIGHT(480)) dut (
    .pixclk    (pixclk),
    .reset     (reset),
    .nextX     (nextX),
    .nextY     (nextY),
    .hSync     (hSync),
    .vSync     (vSync),
    .fb_base   (fb_base),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .underrun  (underrun)
  );

  always #5 pixclk = ~pixclk;

  assign mem_rdata = (mem_addr == 32'h0000_1000) ? 32'hF800_001F
                                                 : {~mem_addr[15:0], mem_addr[15:0]};

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic applyStimulus();
    @(posedge pixclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseHsync();
    hSync = 1'b1;
    applyStimulus();
    hSync = 1'b0;
    applyStimulus();
  endtask

  // Hold mem_ack high until n words have been accepted or the budget runs out.
  task automatic runFetch(input int n, input string tag);
    int got;
    got = 0;
    mem_ack = 1'b1;
    for (int c = 0; c < 4 * n + 20 && got < n; c++) begin
      if (mem_req) got++;
      applyStimulus();
    end
    checkOutput(tag, got, n);
  endtask

  initial begin
    logic [31:0] exp_addr;
    int          words;

    reset   = 1'b1;
    nextX   = 11'd799;
    nextY   = 11'd479;
    hSync   = 1'b0;
    vSync   = 1'b0;
    fb_base = 32'h0000_1000;
    mem_ack = 1'b0;
    repeat (3) applyStimulus();

    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_rgb", {8'd0, red, green, blue}, 32'd0);
    checkOutput("reset_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    applyStimulus();

    // Frame start with mem_ack tied high: lines 0 and 1 back to back.
    mem_ack = 1'b1;
    vSync   = 1'b1;
    applyStimulus();
    vSync = 1'b0;
    applyStimulus();
    checkOutput("first_req", 32'(mem_req), 32'd1);
    checkOutput("first_addr", mem_addr, 32'h0000_1000);
    words = 0;
    for (int c = 0; c < 2000 && words < 800; c++) begin
      if (mem_req) begin
        if (words == 400) checkOutput("line1_base", mem_addr, 32'h0000_1640);
        words++;
      end
      applyStimulus();
    end
    checkOutput("two_line_words", words, 800);
    applyStimulus();
    checkOutput("idle_after_two", 32'(mem_req), 32'd0);

    // Pixel expansion and one-cycle read latency.
    nextY = 11'd0;
    nextX = 11'd0;
    applyStimulus();
    checkOutput("px0_rgb", {8'd0, red, green, blue}, 32'h0000_00FF);
    nextX = 11'd1;
    #2;
    checkOutput("px1_before_edge", {8'd0, red, green, blue}, 32'h0000_00FF);
    applyStimulus();
    checkOutput("px1_rgb", {8'd0, red, green, blue}, 32'h00FF_0000);
    nextY = 11'd1;
    nextX = 11'd2;
    applyStimulus();
    checkOutput("l1_px2_rgb", {8'd0, red, green, blue}, 32'h0010_CB21);
    nextX = 11'd3;
    applyStimulus();
    checkOutput("l1_px3_rgb", {8'd0, red, green, blue}, 32'h00EF_34DE);

    // Scan lines 0..4, each hSync rise fetching line y+2.
    nextX = 11'd0;
    for (int y = 0; y < 5; y++) begin
      nextY = 11'(y);
      pulseHsync();
      runFetch(400, "line_fetch_words");
    end
    checkOutput("no_underrun_scan", 32'(underrun), 32'd0);

    // Line 7 with an ack every third cycle; address held between acks.
    mem_ack = 1'b0;
    nextY   = 11'd5;
    pulseHsync();
    checkOutput("line7_req", 32'(mem_req), 32'd1);
    checkOutput("line7_base", mem_addr, 32'h0000_3BC0);
    exp_addr = 32'h0000_3BC0;
    for (int w = 0; w < 400; w++) begin
      repeat (2) begin
        applyStimulus();
        checkOutput("addr_hold", mem_addr, exp_addr);
      end
      mem_ack = 1'b1;
      applyStimulus();
      mem_ack  = 1'b0;
      exp_addr = exp_addr + 32'd4;
    end
    checkOutput("line7_done", 32'(mem_req), 32'd0);
    nextY = 11'd7;
    nextX = 11'd0;
    applyStimulus();
    checkOutput("l7_px0_rgb", {8'd0, red, green, blue}, 32'h0039_7900);
    checkOutput("no_underrun_l7", 32'(underrun), 32'd0);

    // Three hSync rises with no acks: the third is dropped.
    pulseHsync();
    checkOutput("line8_base", mem_addr, 32'h0000_4200);
    pulseHsync();
    checkOutput("two_pending_ok", 32'(underrun), 32'd0);
    pulseHsync();
    checkOutput("drop_underrun", 32'(underrun), 32'd1);

    // vSync rise aborts the fetch, clears underrun and latches the new base.
    nextY   = 11'd479;
    nextX   = 11'd799;
    fb_base = 32'h0000_2000;
    vSync   = 1'b1;
    applyStimulus();
    vSync = 1'b0;
    checkOutput("vs_clear_underrun", 32'(underrun), 32'd0);
    checkOutput("vs_abort_req", 32'(mem_req), 32'd0);
    applyStimulus();
    checkOutput("new_frame_req", 32'(mem_req), 32'd1);
    checkOutput("new_frame_addr", mem_addr, 32'h0000_2000);
    repeat (3) applyStimulus();
    checkOutput("blank_no_underrun", 32'(underrun), 32'd0);

    // Line 0 shown while mem_ack is held low.
    nextY = 11'd0;
    nextX = 11'd0;
    repeat (2) applyStimulus();
    checkOutput("starved_underrun", 32'(underrun), 32'd1);
    repeat (5) applyStimulus();
    checkOutput("underrun_sticky", 32'(underrun), 32'd1);
    nextY = 11'd479;
    nextX = 11'd799;
    vSync = 1'b1;
    applyStimulus();
    vSync = 1'b0;
    checkOutput("vs_clears_again", 32'(underrun), 32'd0);
    applyStimulus();

    // Reset in the middle of a fetch with mem_ack high.
    mem_ack = 1'b1;
    repeat (3) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkOutput("mid_reset_req", 32'(mem_req), 32'd0);
    checkOutput("mid_reset_addr", mem_addr, 32'd0);
    checkOutput("mid_reset_rgb", {8'd0, red, green, blue}, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus();
      checkOutput("post_reset_idle", 32'(mem_req), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
